// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the shared memory port.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        mem_ready_n;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        i_stall;
  logic        d_stall;
  logic        timeout_err;

  // arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata,
           mem_ready_n, mem_rdata,
    output mem_req, mem_write, mem_size, mem_addr, mem_wdata,
           i_rdata, i_valid, d_rdata, d_valid, i_stall, d_stall, timeout_err
  );

  // pipeline / memory model side
  modport master (
    output i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata,
           mem_ready_n, mem_rdata,
    input  mem_req, mem_write, mem_size, mem_addr, mem_wdata,
           i_rdata, i_valid, d_rdata, d_valid, i_stall, d_stall, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D).
// D wins ties unless it was granted last; a completing access hands the port
// straight to a waiting other side; a watchdog abandons hung accesses.
module mem_port_arbiter #(
  parameter int TIMEOUT = 64
) (
  input logic             clk,
  input logic             rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [15:0] cnt;
  logic        last_d;  // 1: last grant went to D

  // Stalls are purely combinational so the pipeline unfreezes in the valid cycle.
  assign bus.i_stall = bus.i_req & ~bus.i_valid;
  assign bus.d_stall = bus.d_req & ~bus.d_valid;

  // Arbitration FSM, registered memory command and completion/watchdog handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      last_d          <= 1'b1;
      bus.mem_req     <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_size    <= 2'b00;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.i_rdata     <= '0;
      bus.d_rdata     <= '0;
      bus.i_valid     <= 1'b0;
      bus.d_valid     <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.i_valid <= 1'b0;
      bus.d_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.d_req && (!bus.i_req || !last_d)) begin
            state         <= BUSY_D;
            bus.mem_req   <= 1'b1;
            bus.mem_write <= bus.d_write;
            bus.mem_size  <= bus.d_size;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
          end else if (bus.i_req) begin
            state         <= BUSY_I;
            bus.mem_req   <= 1'b1;
            bus.mem_write <= 1'b0;
            bus.mem_size  <= 2'b00;
            bus.mem_addr  <= bus.i_addr;
            bus.mem_wdata <= '0;
          end
        end
        BUSY_I: begin
          if (!bus.mem_ready_n) begin
            bus.i_valid <= 1'b1;
            bus.i_rdata <= bus.mem_rdata;
            last_d      <= 1'b0;
            cnt         <= '0;
            // hand over without an idle bubble; mem_req stays high
            if (bus.d_req) begin
              state         <= BUSY_D;
              bus.mem_write <= bus.d_write;
              bus.mem_size  <= bus.d_size;
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
            end else begin
              state       <= IDLE;
              bus.mem_req <= 1'b0;
            end
          end else if (cnt == CNT_LAST) begin
            state           <= IDLE;
            bus.mem_req     <= 1'b0;
            bus.i_valid     <= 1'b1;
            bus.i_rdata     <= '0;
            bus.timeout_err <= 1'b1;
            last_d          <= 1'b0;
            cnt             <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        BUSY_D: begin
          if (!bus.mem_ready_n) begin
            bus.d_valid <= 1'b1;
            // stores leave the previous load data visible
            if (!bus.mem_write) bus.d_rdata <= bus.mem_rdata;
            last_d      <= 1'b1;
            cnt         <= '0;
            if (bus.i_req) begin
              state         <= BUSY_I;
              bus.mem_write <= 1'b0;
              bus.mem_size  <= 2'b00;
              bus.mem_addr  <= bus.i_addr;
              bus.mem_wdata <= '0;
            end else begin
              state       <= IDLE;
              bus.mem_req <= 1'b0;
            end
          end else if (cnt == CNT_LAST) begin
            state           <= IDLE;
            bus.mem_req     <= 1'b0;
            bus.d_valid     <= 1'b1;
            bus.d_rdata     <= '0;
            bus.timeout_err <= 1'b1;
            last_d          <= 1'b1;
            cnt             <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state       <= IDLE;
          bus.mem_req <= 1'b0;
          cnt         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4); inputs change 1ns after
// each rising edge and outputs are sampled at the same point.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_write = 0; bus.d_size = 2'b00;
    bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ready_n = 1'b1; bus.mem_rdata = '0;

    // reset state
    do_reset();
    chk("rst_mem_req",   32'(bus.mem_req), 0);
    chk("rst_mem_addr",  bus.mem_addr, 0);
    chk("rst_i_valid",   32'(bus.i_valid), 0);
    chk("rst_d_rdata",   bus.d_rdata, 0);
    chk("rst_tmo",       32'(bus.timeout_err), 0);

    // single fetch, ack two cycles after mem_req rises
    bus.i_req = 1; bus.i_addr = 32'h100;
    #1 chk("f_stall_req", 32'(bus.i_stall), 1);
    tick();
    chk("f_mem_req",   32'(bus.mem_req), 1);
    chk("f_mem_addr",  bus.mem_addr, 32'h100);
    chk("f_mem_write", 32'(bus.mem_write), 0);
    chk("f_mem_size",  32'(bus.mem_size), 0);
    tick();
    chk("f_stall_mid", 32'(bus.i_stall), 1);
    chk("f_nvalid",    32'(bus.i_valid), 0);
    bus.mem_ready_n = 0; bus.mem_rdata = 32'h13;
    tick();
    chk("f_valid",     32'(bus.i_valid), 1);
    chk("f_rdata",     bus.i_rdata, 32'h13);
    chk("f_stall_end", 32'(bus.i_stall), 0);
    chk("f_mem_req_0", 32'(bus.mem_req), 0);
    bus.mem_ready_n = 1; bus.i_req = 0;
    tick();
    chk("f_valid_once", 32'(bus.i_valid), 0);

    // simultaneous I and D after reset: I first, then D back-to-back
    do_reset();
    bus.i_req = 1; bus.i_addr = 32'h200;
    bus.d_req = 1; bus.d_write = 0; bus.d_size = 2'b10; bus.d_addr = 32'h2004;
    tick();
    chk("s_grant_i",  bus.mem_addr, 32'h200);
    chk("s_d_stall",  32'(bus.d_stall), 1);
    bus.mem_ready_n = 0; bus.mem_rdata = 32'h1111;
    tick();
    chk("s_i_valid",  32'(bus.i_valid), 1);
    chk("s_i_rdata",  bus.i_rdata, 32'h1111);
    chk("s_req_held", 32'(bus.mem_req), 1);
    chk("s_d_addr",   bus.mem_addr, 32'h2004);
    chk("s_d_size",   32'(bus.mem_size), 2);
    bus.i_req = 0; bus.mem_ready_n = 1;
    tick();
    chk("s_req_busy", 32'(bus.mem_req), 1);
    chk("s_d_nvalid", 32'(bus.d_valid), 0);
    bus.mem_ready_n = 0; bus.mem_rdata = 32'h55;
    tick();
    chk("s_d_valid",  32'(bus.d_valid), 1);
    chk("s_d_rdata",  bus.d_rdata, 32'h55);
    chk("s_req_drop", 32'(bus.mem_req), 0);
    bus.d_req = 0; bus.mem_ready_n = 1;
    tick();

    // store with field hold; d_rdata keeps 0x55
    bus.d_req = 1; bus.d_write = 1; bus.d_size = 2'b00;
    bus.d_addr = 32'h3000; bus.d_wdata = 32'hDEADBEEF;
    tick();
    chk("w_mem_write", 32'(bus.mem_write), 1);
    chk("w_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("w_mem_size",  32'(bus.mem_size), 0);
    bus.d_addr = 32'hFFFF; bus.d_wdata = 32'h0;
    tick();
    chk("w_hold_addr",  bus.mem_addr, 32'h3000);
    chk("w_hold_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("w_hold_write", 32'(bus.mem_write), 1);
    bus.mem_ready_n = 0; bus.mem_rdata = 32'h9999;
    tick();
    chk("w_valid",  32'(bus.d_valid), 1);
    chk("w_rdata",  bus.d_rdata, 32'h55);
    bus.d_req = 0; bus.d_write = 0; bus.mem_ready_n = 1;
    tick();

    // watchdog: ready stuck high, four busy cycles then abandon
    bus.i_req = 1; bus.i_addr = 32'h400;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t_busy%0d", k), 32'(bus.mem_req), 1);
    end
    tick();
    chk("t_req_drop", 32'(bus.mem_req), 0);
    chk("t_valid",    32'(bus.i_valid), 1);
    chk("t_rdata",    bus.i_rdata, 0);
    chk("t_err",      32'(bus.timeout_err), 1);
    bus.i_req = 0;
    tick();
    chk("t_valid_once", 32'(bus.i_valid), 0);
    chk("t_err_stick",  32'(bus.timeout_err), 1);
    bus.d_req = 1; bus.d_addr = 32'h500; bus.d_size = 2'b00;
    tick();
    chk("t_next_addr", bus.mem_addr, 32'h500);
    bus.mem_ready_n = 0; bus.mem_rdata = 32'hAB;
    tick();
    chk("t_next_valid", 32'(bus.d_valid), 1);
    chk("t_next_rdata", bus.d_rdata, 32'hAB);
    chk("t_err_still",  32'(bus.timeout_err), 1);
    bus.d_req = 0; bus.mem_ready_n = 1;
    tick();

    // reset in the middle of a D access
    bus.d_req = 1; bus.d_addr = 32'h600;
    tick();
    chk("r_busy", 32'(bus.mem_req), 1);
    rst = 1;
    tick();
    chk("r_req",    32'(bus.mem_req), 0);
    chk("r_valid",  32'(bus.d_valid), 0);
    chk("r_err",    32'(bus.timeout_err), 0);
    rst = 0; bus.d_req = 0; bus.mem_ready_n = 0; bus.mem_rdata = 32'h77;
    tick();
    chk("r_ack_ign_v", 32'(bus.d_valid), 0);
    chk("r_ack_ign_r", 32'(bus.mem_req), 0);
    bus.mem_ready_n = 1;
    tick();
    chk("r_rdata", bus.d_rdata, 0);
    chk("r_valid2", 32'(bus.d_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single unified memory port between instruction fetch (I side) and the MEM stage load/store path (D side).
- Accepts one request per side and grants one at a time, giving the D side priority with anti-starvation alternation.
- Holds the memory-side command stable until the memory acknowledges with the active-low ready, then returns read data and a one-cycle valid pulse.
- Drives the per-side stall signals the pipeline control uses to freeze IF and MEM, and includes a watchdog against a hung memory.

Parameters:
- TIMEOUT, 64: maximum cycles a granted access may wait for ready before it is abandoned; legal range 2..65535.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- i_req  in  1  fetch request; held high until i_valid
- i_addr  in  32  fetch address; word read
- d_req  in  1  load/store request; held high until d_valid
- d_write  in  1  0 read, 1 write
- d_size  in  2  00 word, 01 half, 10 byte
- d_addr  in  32  data address
- d_wdata  in  32  store data, already lane-formatted
- mem_ready_n  in  1  0: memory completes the current access this cycle
- mem_rdata  in  32  read data, valid when mem_ready_n=0
- mem_req  out  1  access in progress
- mem_write  out  1  0 read, 1 write
- mem_size  out  2  access size
- mem_addr  out  32  access address
- mem_wdata  out  32  write data
- i_rdata  out  32  fetched word, registered
- i_valid  out  1  one-cycle completion pulse, I side
- d_rdata  out  32  loaded word, registered
- d_valid  out  1  one-cycle completion pulse, D side
- i_stall  out  1  i_req & ~i_valid, combinational
- d_stall  out  1  d_req & ~d_valid, combinational
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - mem_req=0, mem_write=0, mem_size=00, mem_addr=0, mem_wdata=0.
  - i_rdata=0, d_rdata=0, i_valid=0, d_valid=0, timeout_err=0.
  - Wait counter is 0 and the last_grant flag is D.
- States: IDLE, BUSY_I, BUSY_D. All mem_* outputs are registered.
- IDLE:
  - If d_req and (~i_req or last_grant==I), go to BUSY_D and latch d_write/d_size/d_addr/d_wdata into mem_*.
  - Else if i_req, go to BUSY_I and latch mem_write=0, mem_size=00, mem_addr=i_addr, mem_wdata=0.
  - mem_req rises on the cycle after the request is first seen, so minimum latency from req to valid is 2 cycles.
- BUSY_x:
  - mem_req=1 and all mem_* fields are held constant. Requester inputs changing mid-access are ignored.
  - The wait counter increments each cycle.
- Completion: on the cycle mem_ready_n=0 is sampled in BUSY_x:
  - Next cycle x_valid=1 for exactly one cycle.
  - For reads, x_rdata is loaded with mem_rdata. For a D write, d_rdata keeps its old value.
  - last_grant is set to x and the counter clears.
- Back-to-back: on completion, if the other side's request is pending, go directly to its BUSY state and latch its fields with no IDLE bubble. mem_req stays 1 across the switch.
  - The same side is never re-granted on the completion cycle, because its req is still high while valid is not yet seen. It returns via IDLE.
- Arbitration: both pending in IDLE means the side not in last_grant wins. Only D pending or only I pending means that side wins.
- Watchdog: if the counter reaches TIMEOUT-1 with mem_ready_n still 1:
  - Abandon the access: mem_req=0 next cycle.
  - Pulse x_valid with x_rdata=0.
  - Set timeout_err=1, which holds until rst.
  - Go to IDLE.
- mem_ready_n is ignored in IDLE, and an acknowledge seen while mem_req=0 is discarded.
- rst mid-access: the next cycle is the reset state, no valid pulse is emitted for the aborted access, and timeout_err clears.
- Widths: the counter is 16 bits. There is no arithmetic on data and no address alignment checks; alignment is the requester's responsibility.

Test Plan:
- Single fetch, i_addr=0x00000100, memory acks 2 cycles after mem_req rises with rdata 0x00000013:
  - mem_req=1, mem_addr=0x100, mem_write=0, mem_size=00.
  - i_valid pulses once with i_rdata=0x13.
  - i_stall is high from the req cycle until the valid cycle.
- Simultaneous i_req and d_req after reset (last_grant=D), with a load from d_addr=0x2004, size 10:
  - I is granted first.
  - On I's ack, the arbiter moves straight to BUSY_D with mem_addr=0x2004 and mem_size=10, and mem_req never drops.
  - d_valid follows D's ack.
- Store d_write=1, d_addr=0x3000, d_wdata=0xDEADBEEF, size 00, with d_rdata previously 0x55:
  - mem_write=1 and mem_wdata=0xDEADBEEF are held for the whole access.
  - d_valid pulses and d_rdata stays 0x55.
- Field hold: change d_addr to 0xFFFF during BUSY_D → mem_addr stays at the latched value until completion.
- Watchdog with TIMEOUT=4 and mem_ready_n stuck at 1:
  - mem_req drops after 4 busy cycles.
  - x_valid pulses with rdata=0 and timeout_err=1 persists.
  - The next request is still served normally.
- rst asserted during BUSY_D:
  - The next cycle has mem_req=0, no d_valid, and timeout_err=0.
  - A later ack pulse is ignored.
